// File: rtl/rv_pkg.sv
// Shared types and lane helpers for the rv_mem load/store stage.
package rv_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } t_mem_size;

    typedef struct packed {
        logic       rd_we;
        logic [4:0] rd_addr;
    } t_wb_ctrl;

    typedef struct packed {
        logic      rd_en;
        logic      wr_en;
        t_mem_size size;
        logic      sign_ext;
        t_wb_ctrl  wb;
    } t_mem_ctrl;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } t_mem_state;

    function automatic logic [3:0] mem_be(input t_mem_size size, input logic [1:0] off);
        case (size)
            SZ_BYTE: mem_be = 4'b0001 << off;
            SZ_HALF: mem_be = 4'b0011 << {off[1], 1'b0};
            SZ_WORD: mem_be = 4'b1111;
            default: mem_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] mem_wr_data(input t_mem_size size, input logic [31:0] data);
        case (size)
            SZ_BYTE: mem_wr_data = {4{data[7:0]}};
            SZ_HALF: mem_wr_data = {2{data[15:0]}};
            SZ_WORD: mem_wr_data = data;
            default: mem_wr_data = data;
        endcase
    endfunction

    // Lane offset used for load alignment; HALF/WORD drop the sub-size address bits.
    function automatic logic [1:0] mem_offset(input t_mem_size size, input logic [1:0] off);
        case (size)
            SZ_BYTE: mem_offset = off;
            SZ_HALF: mem_offset = {off[1], 1'b0};
            SZ_WORD: mem_offset = 2'b00;
            default: mem_offset = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/rv_mem_ld_align.sv
// Combinational load alignment: shift the raw word down to lane 0, then extend.
module rv_mem_ld_align
    import rv_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  t_mem_size   size,
    input  logic        sign_ext,
    output logic [31:0] ld_data
);

    logic [31:0] shifted_s;

    // Lane shift followed by size-dependent zero/sign extension.
    always_comb begin
        shifted_s = data >> {offset, 3'b000};
        case (size)
            SZ_BYTE: ld_data = {{24{sign_ext & shifted_s[7]}}, shifted_s[7:0]};
            SZ_HALF: ld_data = {{16{sign_ext & shifted_s[15]}}, shifted_s[15:0]};
            SZ_WORD: ld_data = shifted_s;
            default: ld_data = shifted_s;
        endcase
    end

endmodule

// File: rtl/rv_mem.sv
// Q103H->Q104H memory stage with an IDLE/REQ/RSP request FSM.
// Define RV_MEM_MISALIGN_CHK_EN to trap misaligned HALF/WORD accesses.
module rv_mem
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_Q103H,
    input  t_mem_ctrl   ctrl_Q103H,
    input  logic [31:0] alu_out_Q103H,
    input  logic [31:0] rs2_data_Q103H,
    output logic        stall_Q103H,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wr_data,
    input  logic        dmem_gnt,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_data,
    output logic        valid_Q104H,
    output t_wb_ctrl    ctrl_wb_Q104H,
    output logic [31:0] pre_wb_data_Q104H,
    output logic [31:0] dmem_rd_data_Q104H,
    output logic        misalign_Q104H
);

    t_mem_state  state_r, state_nxt_s;
    logic        mem_op_s, is_store_s, misalign_s;
    logic        issue_s, done_s, ld_done_s;
    logic        we_r;
    logic [31:0] addr_r, wdata_r;
    logic [3:0]  be_r;
    logic [1:0]  ld_off_r;
    t_mem_size   ld_size_r;
    logic        ld_sext_r;
    logic [31:0] ld_data_s;

    assign mem_op_s   = valid_Q103H & (ctrl_Q103H.rd_en | ctrl_Q103H.wr_en);
    assign is_store_s = ctrl_Q103H.wr_en;

`ifdef RV_MEM_MISALIGN_CHK_EN
    assign misalign_s = mem_op_s &
                        (((ctrl_Q103H.size == SZ_HALF) & alu_out_Q103H[0]) |
                         ((ctrl_Q103H.size == SZ_WORD) & (alu_out_Q103H[1:0] != 2'b00)));
`else
    assign misalign_s = 1'b0;
`endif

    // Request/completion decode; IDLE drives the bus straight from Q103H, REQ replays the captured request.
    always_comb begin
        state_nxt_s  = state_r;
        done_s       = 1'b0;
        ld_done_s    = 1'b0;
        issue_s      = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = we_r;
        dmem_addr    = addr_r;
        dmem_be      = be_r;
        dmem_wr_data = wdata_r;
        case (state_r)
            ST_IDLE: begin
                dmem_we      = is_store_s;
                dmem_addr    = {alu_out_Q103H[31:2], 2'b00};
                dmem_be      = mem_be(ctrl_Q103H.size, alu_out_Q103H[1:0]);
                dmem_wr_data = mem_wr_data(ctrl_Q103H.size, rs2_data_Q103H);
                if (valid_Q103H && !mem_op_s) begin
                    done_s = 1'b1;
                end else if (misalign_s) begin
                    done_s = 1'b1;
                end else if (mem_op_s) begin
                    dmem_req = 1'b1;
                    issue_s  = 1'b1;
                    if (dmem_gnt) begin
                        if (is_store_s) begin
                            done_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_RSP;
                        end
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end else begin
                    done_s = 1'b0;
                end
            end
            ST_REQ: begin
                dmem_req = 1'b1;
                if (dmem_gnt) begin
                    if (we_r) begin
                        done_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RSP;
                    end
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_RSP: begin
                if (dmem_rsp_valid) begin
                    done_s      = 1'b1;
                    ld_done_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RSP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign stall_Q103H = valid_Q103H & ~done_s;

    rv_mem_ld_align u_ld_align (
        .data     (dmem_rsp_data),
        .offset   (ld_off_r),
        .size     (ld_size_r),
        .sign_ext (ld_sext_r),
        .ld_data  (ld_data_s)
    );

    // FSM state and request capture at issue time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            we_r      <= 1'b0;
            addr_r    <= 32'h0000_0000;
            be_r      <= 4'b0000;
            wdata_r   <= 32'h0000_0000;
            ld_off_r  <= 2'b00;
            ld_size_r <= SZ_BYTE;
            ld_sext_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (issue_s) begin
                we_r      <= dmem_we;
                addr_r    <= dmem_addr;
                be_r      <= dmem_be;
                wdata_r   <= dmem_wr_data;
                ld_off_r  <= mem_offset(ctrl_Q103H.size, alu_out_Q103H[1:0]);
                ld_size_r <= ctrl_Q103H.size;
                ld_sext_r <= ctrl_Q103H.sign_ext;
            end
        end
    end

    // Q104H pipeline register: bubbles while stalled, payload holds until the next completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_Q104H        <= 1'b0;
            ctrl_wb_Q104H      <= '0;
            pre_wb_data_Q104H  <= 32'h0000_0000;
            dmem_rd_data_Q104H <= 32'h0000_0000;
            misalign_Q104H     <= 1'b0;
        end else begin
            valid_Q104H <= done_s;
            if (done_s) begin
                ctrl_wb_Q104H      <= ctrl_Q103H.wb;
                pre_wb_data_Q104H  <= alu_out_Q103H;
                dmem_rd_data_Q104H <= ld_done_s ? ld_data_s : 32'h0000_0000;
                misalign_Q104H     <= (state_r == ST_IDLE) & misalign_s;
            end
        end
    end

endmodule

// File: tb/tb_rv_mem.sv
// Directed bench for rv_mem: stimulus pushes expected Q104H results, a negedge monitor pops and compares.
module tb_rv_mem;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_Q103H;
    t_mem_ctrl   ctrl_Q103H;
    logic [31:0] alu_out_Q103H, rs2_data_Q103H;
    logic        stall_Q103H, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wr_data;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rsp_valid;
    logic [31:0] dmem_rsp_data;
    logic        valid_Q104H, misalign_Q104H;
    t_wb_ctrl    ctrl_wb_Q104H;
    logic [31:0] pre_wb_data_Q104H, dmem_rd_data_Q104H;

    typedef struct {
        logic [31:0] pre;
        logic [31:0] rd;
        logic        mis;
        t_wb_ctrl    wb;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   stalls, held;

    always #5 clk = ~clk;

    rv_mem dut (
        .clk                (clk),
        .rst                (rst),
        .valid_Q103H        (valid_Q103H),
        .ctrl_Q103H         (ctrl_Q103H),
        .alu_out_Q103H      (alu_out_Q103H),
        .rs2_data_Q103H     (rs2_data_Q103H),
        .stall_Q103H        (stall_Q103H),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_be            (dmem_be),
        .dmem_wr_data       (dmem_wr_data),
        .dmem_gnt           (dmem_gnt),
        .dmem_rsp_valid     (dmem_rsp_valid),
        .dmem_rsp_data      (dmem_rsp_data),
        .valid_Q104H        (valid_Q104H),
        .ctrl_wb_Q104H      (ctrl_wb_Q104H),
        .pre_wb_data_Q104H  (pre_wb_data_Q104H),
        .dmem_rd_data_Q104H (dmem_rd_data_Q104H),
        .misalign_Q104H     (misalign_Q104H)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic t_mem_ctrl mk(input logic rd, input logic wr, input t_mem_size sz,
                                     input logic sx, input logic we, input logic [4:0] ra);
        t_mem_ctrl c;
        c.rd_en       = rd;
        c.wr_en       = wr;
        c.size        = sz;
        c.sign_ext    = sx;
        c.wb.rd_we    = we;
        c.wb.rd_addr  = ra;
        return c;
    endfunction

    task automatic push(input logic [31:0] pre, input logic [31:0] rd, input logic mis);
        exp_t e;
        e.pre = pre;
        e.rd  = rd;
        e.mis = mis;
        e.wb  = ctrl_Q103H.wb;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        valid_Q103H    = 1'b0;
        ctrl_Q103H     = '0;
        alu_out_Q103H  = 32'h0;
        rs2_data_Q103H = 32'h0;
        dmem_gnt       = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_data  = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every Q104H valid must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && valid_Q104H !== 1'b0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid_Q104H: got %b expected 0", valid_Q104H);
            end else begin
                e = exp_q.pop_front();
                chk("pre_wb_data_Q104H", pre_wb_data_Q104H, e.pre);
                chk("dmem_rd_data_Q104H", dmem_rd_data_Q104H, e.rd);
                chk("misalign_Q104H", {31'd0, misalign_Q104H}, {31'd0, e.mis});
                chk("ctrl_wb_Q104H", {26'd0, ctrl_wb_Q104H}, {26'd0, e.wb});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid_Q104H", {31'd0, valid_Q104H}, 32'd0);
        chk("reset_pre_wb", pre_wb_data_Q104H, 32'd0);
        chk("reset_rd_data", dmem_rd_data_Q104H, 32'd0);
        chk("reset_misalign", {31'd0, misalign_Q104H}, 32'd0);
        chk("reset_ctrl_wb", {26'd0, ctrl_wb_Q104H}, 32'd0);
        chk("reset_dmem_req", {31'd0, dmem_req}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // ALU op: latency 1, no request, stray gnt ignored
        valid_Q103H = 1'b1; ctrl_Q103H = mk(1'b0, 1'b0, SZ_WORD, 1'b0, 1'b1, 5'd1);
        alu_out_Q103H = 32'h0000_1234; dmem_gnt = 1'b1;
        push(32'h0000_1234, 32'h0, 1'b0);
        @(negedge clk);
        chk("alu_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("alu_stall", {31'd0, stall_Q103H}, 32'd0);
        tick(); idle_inputs(); @(negedge clk); tick();

        // SB 0xAB at 0x102, granted immediately
        valid_Q103H = 1'b1; ctrl_Q103H = mk(1'b0, 1'b1, SZ_BYTE, 1'b0, 1'b0, 5'd0);
        alu_out_Q103H = 32'h0000_0102; rs2_data_Q103H = 32'hDEAD_BEAB; dmem_gnt = 1'b1;
        push(32'h0000_0102, 32'h0, 1'b0);
        @(negedge clk);
        chk("sb_req", {31'd0, dmem_req}, 32'd1);
        chk("sb_we", {31'd0, dmem_we}, 32'd1);
        chk("sb_be", {28'd0, dmem_be}, 32'h4);
        chk("sb_wr_data", dmem_wr_data, 32'hABAB_ABAB);
        chk("sb_addr", dmem_addr, 32'h0000_0100);
        chk("sb_stall", {31'd0, stall_Q103H}, 32'd0);
        tick(); idle_inputs(); @(negedge clk); tick();

        // LB signed at 0x203, response arrives on the third cycle after grant
        valid_Q103H = 1'b1; ctrl_Q103H = mk(1'b1, 1'b0, SZ_BYTE, 1'b1, 1'b1, 5'd3);
        alu_out_Q103H = 32'h0000_0203; dmem_gnt = 1'b1;
        push(32'h0000_0203, 32'hFFFF_FF80, 1'b0);
        stalls = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h8000_0000; end
            @(negedge clk);
            if (stall_Q103H) stalls++;
            if (c == 0) chk("lb_be", {28'd0, dmem_be}, 32'h8);
            if (c == 1) chk("lb_rsp_no_req", {31'd0, dmem_req}, 32'd0);
            tick();
            if (c == 0) dmem_gnt = 1'b0;
        end
        idle_inputs();
        chk("lb_stall_cycles", stalls, 32'd3);
        @(negedge clk); tick();

        // LHU at 0x202, grant after 3 waits, stray rsp_valid in REQ ignored
        valid_Q103H = 1'b1; ctrl_Q103H = mk(1'b1, 1'b0, SZ_HALF, 1'b0, 1'b1, 5'd4);
        alu_out_Q103H = 32'h0000_0202;
        push(32'h0000_0202, 32'h0000_BEEF, 1'b0);
        held = 0;
        for (int c = 0; c < 5; c++) begin
            dmem_rsp_valid = (c == 1); dmem_rsp_data = (c == 1) ? 32'hFFFF_FFFF : 32'h0;
            if (c == 3) dmem_gnt = 1'b1;
            if (c == 4) begin dmem_gnt = 1'b0; dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'hBEEF_1234; end
            @(negedge clk);
            if (dmem_req) held++;
            if (c < 4) begin
                chk("lhu_addr", dmem_addr, 32'h0000_0200);
                chk("lhu_be", {28'd0, dmem_be}, 32'hC);
                chk("lhu_we", {31'd0, dmem_we}, 32'd0);
                chk("lhu_stall", {31'd0, stall_Q103H}, 32'd1);
            end
            tick();
        end
        idle_inputs();
        chk("lhu_req_cycles", held, 32'd4);
        @(negedge clk); tick();

        // Reset pulsed while waiting in RSP; late response must be dropped
        valid_Q103H = 1'b1; ctrl_Q103H = mk(1'b1, 1'b0, SZ_WORD, 1'b0, 1'b1, 5'd5);
        alu_out_Q103H = 32'h0000_0300; dmem_gnt = 1'b1;
        @(negedge clk);
        chk("rst_ld_req", {31'd0, dmem_req}, 32'd1);
        tick(); dmem_gnt = 1'b0;
        @(negedge clk);
        chk("rst_in_rsp_stall", {31'd0, stall_Q103H}, 32'd1);
        #1 rst = 1'b0; idle_inputs();
        #2 rst = 1'b1;
        tick(); dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h5555_5555;
        @(negedge clk);
        chk("late_rsp_req", {31'd0, dmem_req}, 32'd0);
        chk("late_rsp_valid_Q104H", {31'd0, valid_Q104H}, 32'd0);
        tick(); dmem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid_Q104H", {31'd0, valid_Q104H}, 32'd0);
        chk("post_rst_pre_wb", pre_wb_data_Q104H, 32'd0);
        chk("post_rst_rd_data", dmem_rd_data_Q104H, 32'd0);
        tick();
        valid_Q103H = 1'b1; ctrl_Q103H = mk(1'b0, 1'b0, SZ_WORD, 1'b0, 1'b1, 5'd7);
        alu_out_Q103H = 32'h0000_CAFE;
        push(32'h0000_CAFE, 32'h0, 1'b0);
        @(negedge clk);
        chk("post_rst_alu_stall", {31'd0, stall_Q103H}, 32'd0);
        tick(); idle_inputs(); @(negedge clk); tick();

        // LW at 0x101: trapped when checking is enabled, word-aligned access otherwise
        valid_Q103H = 1'b1; ctrl_Q103H = mk(1'b1, 1'b0, SZ_WORD, 1'b0, 1'b1, 5'd8);
        alu_out_Q103H = 32'h0000_0101;
`ifdef RV_MEM_MISALIGN_CHK_EN
        push(32'h0000_0101, 32'h0, 1'b1);
        @(negedge clk);
        chk("mis_lw_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_lw_stall", {31'd0, stall_Q103H}, 32'd0);
        tick(); idle_inputs(); @(negedge clk); tick();
`else
        push(32'h0000_0101, 32'h1122_3344, 1'b0);
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk("lw_101_req", {31'd0, dmem_req}, 32'd1);
        chk("lw_101_addr", dmem_addr, 32'h0000_0100);
        chk("lw_101_be", {28'd0, dmem_be}, 32'hF);
        tick(); dmem_gnt = 1'b0; dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h1122_3344;
        @(negedge clk);
        chk("lw_101_rsp_stall", {31'd0, stall_Q103H}, 32'd0);
        tick(); idle_inputs(); @(negedge clk); tick();
`endif

        // rd_en+wr_en SH at 0x106 behaves as a store, grant after one wait
        valid_Q103H = 1'b1; ctrl_Q103H = mk(1'b1, 1'b1, SZ_HALF, 1'b0, 1'b0, 5'd0);
        alu_out_Q103H = 32'h0000_0106; rs2_data_Q103H = 32'h1234_5678;
        push(32'h0000_0106, 32'h0, 1'b0);
        @(negedge clk);
        chk("sh_be", {28'd0, dmem_be}, 32'hC);
        chk("sh_wr_data", dmem_wr_data, 32'h5678_5678);
        chk("sh_we", {31'd0, dmem_we}, 32'd1);
        chk("sh_wait_stall", {31'd0, stall_Q103H}, 32'd1);
        tick(); dmem_gnt = 1'b1;
        @(negedge clk);
        chk("sh_req_held", {31'd0, dmem_req}, 32'd1);
        chk("sh_wr_data_held", dmem_wr_data, 32'h5678_5678);
        chk("sh_gnt_stall", {31'd0, stall_Q103H}, 32'd0);
        tick(); idle_inputs(); @(negedge clk); tick();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
